// File: rtl/siso_pkg.sv
// Shared definitions for the 8-state SISO decoder datapath: widths,
// frame-length limits, decoder phase encoding and the branch-metric pair.
package siso_pkg;

    localparam int LLR_W       = 8;
    localparam int BM_W        = 16;
    localparam int ADDR_W      = 13;
    localparam int FRAME_DEPTH = 6144;

    localparam logic [ADDR_W-1:0] MIN_K = 13'd40;
    localparam logic [ADDR_W-1:0] MAX_K = 13'd6144;

    // Phase encoding is shared with the alpha and beta recursions.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_FWD  = 2'b01,
        ST_BWD  = 2'b10,
        ST_DONE = 2'b11
    } siso_state_t;

    typedef struct packed {
        logic signed [BM_W-1:0] branch1;
        logic signed [BM_W-1:0] branch2;
    } bm_pair_t;

endpackage

// File: rtl/bm_frame_ram.sv
// Simple dual-port synchronous frame buffer for branch-metric pairs.
// One write port and one read port on the same clock, 1-cycle read latency.
module bm_frame_ram
    import siso_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [2*BM_W-1:0]   wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [2*BM_W-1:0]   rd_data
);

    logic [2*BM_W-1:0] mem [FRAME_DEPTH];

    // Store one metric pair per accepted trellis step.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Registered read; data is available the cycle after the issue.
    always_ff @(posedge clk) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/branch_metric_unit.sv
// Branch metric unit: computes branch1/branch2 per trellis step, streams them
// to the alpha recursion, buffers the frame and replays it reversed for beta.
module branch_metric_unit
    import siso_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   frame_len,
    output logic                len_err,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LLR_W-1:0]    in_sys,
    input  logic [LLR_W-1:0]    in_par,
    input  logic [LLR_W-1:0]    in_apr,
    output logic                fwd_valid,
    output logic [BM_W-1:0]     fwd_branch1,
    output logic [BM_W-1:0]     fwd_branch2,
    output logic                bwd_valid,
    output logic [BM_W-1:0]     bwd_branch1,
    output logic [BM_W-1:0]     bwd_branch2,
    output logic                bwd_last,
    output logic [1:0]          fsm_state
);

    // Sign-extend, sum and halve with floor rounding; the sum cannot overflow BM_W.
    function automatic bm_pair_t calc_metrics(input logic signed [LLR_W-1:0] s,
                                              input logic signed [LLR_W-1:0] p,
                                              input logic signed [LLR_W-1:0] a);
        logic signed [BM_W-1:0] s_x;
        logic signed [BM_W-1:0] p_x;
        logic signed [BM_W-1:0] a_x;
        logic signed [BM_W-1:0] sum1;
        logic signed [BM_W-1:0] sum2;
        bm_pair_t               pair;
        s_x  = {{(BM_W-LLR_W){s[LLR_W-1]}}, s};
        p_x  = {{(BM_W-LLR_W){p[LLR_W-1]}}, p};
        a_x  = {{(BM_W-LLR_W){a[LLR_W-1]}}, a};
        sum1 = s_x + a_x + p_x;
        sum2 = s_x + a_x - p_x;
        pair.branch1 = sum1 >>> 1;
        pair.branch2 = sum2 >>> 1;
        return pair;
    endfunction

    siso_state_t        state;
    siso_state_t        state_next;
    logic [ADDR_W-1:0]  k_len;
    logic [ADDR_W-1:0]  wr_cnt;
    logic [ADDR_W-1:0]  rd_addr;
    logic               rd_gap;
    logic               rd_done;
    logic               rd_en;
    logic               len_ok;
    logic               start_ok;
    logic               accept;
    bm_pair_t           bm_p0;
    logic [2*BM_W-1:0]  ram_rd_p1;
    logic               vld_p1;
    logic               last_p1;

    assign len_ok   = (frame_len >= MIN_K) && (frame_len <= MAX_K);
    assign start_ok = (state == ST_IDLE) && start && len_ok;
    assign accept   = in_valid && in_ready;
    assign bm_p0    = calc_metrics(in_sys, in_par, in_apr);

    // Phase register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Phase transitions: forward until all K beats are out, reverse until the step-0 beat.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (start_ok)         state_next = ST_FWD;
            ST_FWD:  if (wr_cnt == k_len)  state_next = ST_BWD;
            ST_BWD:  if (bwd_last)         state_next = ST_DONE;
            default:                       state_next = ST_IDLE;
        endcase
    end

    // Handshake and read-issue decode; ready drops the cycle after each accept.
    always_comb begin
        fsm_state = state;
        in_ready  = (state == ST_FWD) && !fwd_valid && (wr_cnt != k_len);
        rd_en     = (state == ST_BWD) && !rd_gap && !rd_done;
    end

    // Frame length latch, write counter and reverse read address generator.
    always_ff @(posedge clk) begin
        if (rst) begin
            k_len   <= '0;
            wr_cnt  <= '0;
            rd_addr <= '0;
            rd_gap  <= 1'b0;
            rd_done <= 1'b0;
            len_err <= 1'b0;
        end else begin
            len_err <= (state == ST_IDLE) && start && !len_ok;
            if (start_ok) begin
                k_len   <= frame_len;
                wr_cnt  <= '0;
                rd_addr <= frame_len - ADDR_W'(1);
                rd_gap  <= 1'b0;
                rd_done <= 1'b0;
            end
            if (accept) begin
                wr_cnt <= wr_cnt + ADDR_W'(1);
            end
            if (state == ST_BWD) begin
                rd_gap <= rd_en;
            end
            if (rd_en) begin
                if (rd_addr == '0) begin
                    rd_done <= 1'b1;
                end else begin
                    rd_addr <= rd_addr - ADDR_W'(1);
                end
            end
        end
    end

    bm_frame_ram u_ram (
        .clk     (clk),
        .wr_en   (accept),
        .wr_addr (wr_cnt),
        .wr_data (bm_p0),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (ram_rd_p1)
    );

    // Stage p0 -> p1: forward metrics registered one cycle after the accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_valid   <= 1'b0;
            fwd_branch1 <= '0;
            fwd_branch2 <= '0;
        end else begin
            fwd_valid <= accept;
            if (accept) begin
                fwd_branch1 <= bm_p0.branch1;
                fwd_branch2 <= bm_p0.branch2;
            end
        end
    end

    // Stage p1 -> p2: RAM output registered, valid and last follow the read issue.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1      <= 1'b0;
            last_p1     <= 1'b0;
            bwd_valid   <= 1'b0;
            bwd_last    <= 1'b0;
            bwd_branch1 <= '0;
            bwd_branch2 <= '0;
        end else begin
            vld_p1    <= rd_en;
            last_p1   <= rd_en && (rd_addr == '0);
            bwd_valid <= vld_p1;
            bwd_last  <= last_p1;
            if (vld_p1) begin
                {bwd_branch1, bwd_branch2} <= ram_rd_p1;
            end
        end
    end

endmodule

// File: tb/tb_branch_metric_unit.sv
// Self-checking bench for branch_metric_unit: table vectors for metric values
// and length limits, plus randomized frames against a behavioural model.
module tb_branch_metric_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [12:0] frame_len;
    logic        len_err;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_sys;
    logic [7:0]  in_par;
    logic [7:0]  in_apr;
    logic        fwd_valid;
    logic [15:0] fwd_branch1;
    logic [15:0] fwd_branch2;
    logic        bwd_valid;
    logic [15:0] bwd_branch1;
    logic [15:0] bwd_branch2;
    logic        bwd_last;
    logic [1:0]  fsm_state;

    int tests = 0;
    int fails = 0;

    typedef struct { int s; int p; int a; int b1; int b2; } bm_vec_t;
    typedef struct { int k; int err; } len_vec_t;

    bm_vec_t  bm_tab[9];
    len_vec_t len_tab[4];

    int s_arr[6144];
    int p_arr[6144];
    int a_arr[6144];
    int e1_arr[6144];
    int e2_arr[6144];

    branch_metric_unit dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .frame_len   (frame_len),
        .len_err     (len_err),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_sys      (in_sys),
        .in_par      (in_par),
        .in_apr      (in_apr),
        .fwd_valid   (fwd_valid),
        .fwd_branch1 (fwd_branch1),
        .fwd_branch2 (fwd_branch2),
        .bwd_valid   (bwd_valid),
        .bwd_branch1 (bwd_branch1),
        .bwd_branch2 (bwd_branch2),
        .bwd_last    (bwd_last),
        .fsm_state   (fsm_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    // Floor of x/2 from integer division (which truncates toward zero).
    function automatic int floor_half(input int x);
        int q;
        q = x / 2;
        if (x < 0 && (x % 2) != 0) q = q - 1;
        return q;
    endfunction

    function automatic int rand_llr();
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".len_err"},   len_err, 0);
        check({tag, ".in_ready"},  in_ready, 0);
        check({tag, ".fwd_valid"}, fwd_valid, 0);
        check({tag, ".fwd_b1"},    fwd_branch1, 0);
        check({tag, ".fwd_b2"},    fwd_branch2, 0);
        check({tag, ".bwd_valid"}, bwd_valid, 0);
        check({tag, ".bwd_b1"},    bwd_branch1, 0);
        check({tag, ".bwd_b2"},    bwd_branch2, 0);
        check({tag, ".bwd_last"},  bwd_last, 0);
        check({tag, ".fsm_state"}, fsm_state, 0);
    endtask

    // mode 0: random LLRs, mode 1: ramp s=i, mode 2: table vectors first then random
    task automatic prepare(input int k, input int mode);
        for (int i = 0; i < k; i++) begin
            if (mode == 1) begin
                s_arr[i] = i; p_arr[i] = 0; a_arr[i] = 0;
            end else begin
                s_arr[i] = rand_llr(); p_arr[i] = rand_llr(); a_arr[i] = rand_llr();
            end
            e1_arr[i] = floor_half(s_arr[i] + a_arr[i] + p_arr[i]);
            e2_arr[i] = floor_half(s_arr[i] + a_arr[i] - p_arr[i]);
        end
        if (mode == 2) begin
            for (int j = 0; j < 9; j++) begin
                s_arr[j]  = bm_tab[j].s;
                p_arr[j]  = bm_tab[j].p;
                a_arr[j]  = bm_tab[j].a;
                e1_arr[j] = bm_tab[j].b1;
                e2_arr[j] = bm_tab[j].b2;
            end
        end
    endtask

    task automatic run_frame(input int k, input int mode, input bit hold,
                             input bit inject, input int rst_after);
        int acc;
        int fwd;
        int bwd;
        int cyc;
        int budget;
        int last_fwd_cyc;
        int exp_state;
        int idx;
        bit exp_bwd;
        bit prev_acc;
        bit done_seen;
        bit finished;
        bit inj_f;
        bit inj_b;
        bit inj_d;
        prepare(k, mode);
        acc = 0; fwd = 0; bwd = 0; cyc = 0; last_fwd_cyc = 0;
        prev_acc = 0; done_seen = 0; finished = 0;
        inj_f = 0; inj_b = 0; inj_d = 0;
        budget = 8 * k + 100;
        start = 1'b1;
        frame_len = 13'(k);
        in_valid = 1'b0;
        tick();
        start = 1'b0;
        while (!finished && cyc < budget) begin
            if (fwd < k)         exp_state = 1;
            else if (bwd < k)    exp_state = 2;
            else if (!done_seen) exp_state = 3;
            else                 exp_state = 0;
            check("fsm_state", fsm_state, exp_state);
            check("in_ready", in_ready, int'(exp_state == 1 && !prev_acc && acc < k));
            check("fwd_valid", fwd_valid, prev_acc);
            check("len_err_busy", len_err, 0);
            if (fwd_valid) begin
                if (fwd < k) begin
                    check("fwd_branch1", int'($signed(fwd_branch1)), e1_arr[fwd]);
                    check("fwd_branch2", int'($signed(fwd_branch2)), e2_arr[fwd]);
                end
                fwd++;
                last_fwd_cyc = cyc;
            end
            exp_bwd = (fwd >= k) && (bwd < k) && (cyc == last_fwd_cyc + 3 + 2 * bwd);
            check("bwd_valid", bwd_valid, exp_bwd);
            idx = k - 1 - bwd;
            check("bwd_last", bwd_last, int'(bwd_valid && idx == 0));
            if (bwd_valid) begin
                if (bwd < k) begin
                    check("bwd_branch1", int'($signed(bwd_branch1)), e1_arr[idx]);
                    check("bwd_branch2", int'($signed(bwd_branch2)), e2_arr[idx]);
                end
                bwd++;
            end
            if (exp_state == 3) done_seen = 1;
            if (exp_state == 0) finished = 1;
            if (rst_after > 0 && acc == rst_after) begin
                rst = 1'b1;
                in_valid = 1'b0;
                tick();
                check_zero("abort");
                rst = 1'b0;
                tick();
                check("abort_idle_state", fsm_state, 0);
                check("abort_idle_fwd", fwd_valid, 0);
                check("abort_idle_bwd", bwd_valid, 0);
                return;
            end
            start = 1'b0;
            if (inject) begin
                if (exp_state == 1 && acc == 10 && !inj_f) begin
                    start = 1'b1; frame_len = 13'd39; inj_f = 1;
                end
                if (exp_state == 2 && bwd == 5 && !inj_b) begin
                    start = 1'b1; frame_len = 13'd40; inj_b = 1;
                end
                if (exp_state == 3 && !inj_d) begin
                    start = 1'b1; frame_len = 13'd40; inj_d = 1;
                end
            end
            if (acc < k && !finished) in_valid = hold ? 1'b1 : 1'($urandom_range(0, 1));
            else                      in_valid = hold ? 1'b0 : 1'($urandom_range(0, 1));
            if (in_valid && acc < k) begin
                in_sys = 8'(s_arr[acc]);
                in_par = 8'(p_arr[acc]);
                in_apr = 8'(a_arr[acc]);
            end else begin
                in_sys = 8'($urandom);
                in_par = 8'($urandom);
                in_apr = 8'($urandom);
            end
            prev_acc = in_valid && in_ready;
            if (prev_acc) acc++;
            tick();
            cyc++;
        end
        start = 1'b0;
        in_valid = 1'b0;
        check("frame_done", finished, 1);
        check("fwd_count", fwd, k);
        check("bwd_count", bwd, k);
    endtask

    initial begin
        bm_tab[0] = '{10,    4,    2,    8,    4};
        bm_tab[1] = '{-7,    0,    0,   -4,   -4};
        bm_tab[2] = '{127,  127,  127, 190,   63};
        bm_tab[3] = '{-128, -128, -128, -192, -64};
        bm_tab[4] = '{-128,  127, -128, -65, -192};
        bm_tab[5] = '{1,     0,    0,    0,    0};
        bm_tab[6] = '{-1,    0,    0,   -1,   -1};
        bm_tab[7] = '{0,    -3,    0,   -2,    1};
        bm_tab[8] = '{5,    -2,   -4,   -1,    1};
        len_tab[0] = '{39,   1};
        len_tab[1] = '{6145, 1};
        len_tab[2] = '{0,    1};
        len_tab[3] = '{8191, 1};

        rst = 1'b1;
        start = 1'b0;
        frame_len = '0;
        in_valid = 1'b0;
        in_sys = '0;
        in_par = '0;
        in_apr = '0;
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check("idle_state", fsm_state, 0);
        check("idle_ready", in_ready, 0);

        for (int i = 0; i < 4; i++) begin
            start = 1'b1;
            frame_len = 13'(len_tab[i].k);
            tick();
            start = 1'b0;
            check("len_err_pulse", len_err, len_tab[i].err);
            check("len_err_state", fsm_state, 0);
            check("len_err_ready", in_ready, 0);
            tick();
            check("len_err_clear", len_err, 0);
            check("len_err_state2", fsm_state, 0);
        end

        run_frame(40, 2, 1'b1, 1'b0, 0);
        run_frame(40, 1, 1'b0, 1'b0, 0);
        run_frame(40, 0, 1'b0, 1'b1, 0);
        run_frame(40, 0, 1'b1, 1'b0, 20);
        run_frame(40, 0, 1'b0, 1'b0, 0);
        run_frame(6144, 0, 1'b1, 1'b0, 0);
        run_frame(57, 0, 1'b0, 1'b1, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/branch_metric_unit.md
Name: branch_metric_unit

Overview:
- Upstream stage of the 8-state SISO decoder; feeds the alpha (forward state-metric) recursion and the beta recursion.
- Accepts per-trellis-step channel and a-priori LLRs, and computes the two branch metrics branch1 and branch2.
- Streams the metrics forward to alpha, stores them in a frame buffer, then replays them in reverse order for beta.
- Generates fsm_state for the decoder. Alpha resets its metrics whenever fsm_state is 00.

Parameters:
- LLR_W, 8, width of the signed input LLRs.
- BM_W, 16, width of the signed branch-metric outputs.
- MAX_K, 6144, maximum frame length (trellis steps, tail excluded).
- MIN_K, 40, minimum legal frame length.
- ADDR_W, 13, frame-buffer address width; must satisfy 2^ADDR_W >= MAX_K.

Ports:
- clk, in, 1, clock.
- rst, in, 1, reset: synchronous, active-high.
- start, in, 1, single-cycle frame start; honoured only in IDLE.
- frame_len, in, ADDR_W, frame length K; sampled when start is honoured.
- len_err, out, 1, one-cycle pulse when start arrives in IDLE with K < MIN_K or K > MAX_K.
- in_valid, in, 1, input sample valid.
- in_ready, out, 1, block can accept a sample.
- in_sys, in, LLR_W, systematic LLR, signed.
- in_par, in, LLR_W, parity LLR, signed.
- in_apr, in, LLR_W, a-priori LLR, signed.
- fwd_valid, out, 1, forward metric valid; drives alpha valid_branch.
- fwd_branch1, out, BM_W, forward branch1; drives alpha init_branch1.
- fwd_branch2, out, BM_W, forward branch2; drives alpha init_branch2.
- bwd_valid, out, 1, reversed metric valid.
- bwd_branch1, out, BM_W, reversed branch1.
- bwd_branch2, out, BM_W, reversed branch2.
- bwd_last, out, 1, marks the bwd beat for step 0.
- fsm_state, out, 2, decoder phase: 00 IDLE, 01 FWD, 10 BWD, 11 DONE.

Behaviour:
- Reset values: all outputs 0, state IDLE, counters 0. Frame-buffer contents are don't-care.
- Reset mid-frame aborts the frame: IDLE on the next edge, no further valid beats.
- Arithmetic: sign-extend s, p, a to BM_W.
  - branch1 = (s + a + p) >>> 1
  - branch2 = (s + a − p) >>> 1
  - Shift is arithmetic, floor rounding. No saturation is needed; |sum| ≤ 3·2^(LLR_W−1) fits BM_W.
- IDLE:
  - in_ready = 0.
  - Legal start: latch K, clear counter, go to FWD.
  - Illegal start: pulse len_err, stay in IDLE.
- FWD:
  - in_ready = !fwd_valid, i.e. ready is low the cycle after each accept.
  - Throughput is therefore at most one sample per 2 cycles. Alpha relies on this: valid-low cycles commit its recursion.
  - An accept (in_valid && in_ready) registers branch1/branch2 onto fwd_* with fwd_valid = 1 for exactly one cycle, 1 cycle after the accept.
  - Write the same pair to buffer address wr_cnt, then increment wr_cnt.
  - in_valid while in_ready = 0 is not accepted; the source holds its data.
  - After the K-th accept, go to BWD on the next edge; in_ready = 0 from then on.
- BWD:
  - Issue buffer reads at addresses K−1 down to 0, one read every 2 cycles (issue, gap, issue, ...).
  - Synchronous RAM read latency is 1; register the output, so bwd_valid asserts 2 cycles after the read issue.
  - bwd_valid is never high on two consecutive cycles.
  - bwd_last = 1 together with the address-0 beat.
  - After the bwd_last beat, go to DONE.
- DONE: held for exactly 1 cycle, then IDLE. A start during DONE is ignored, as is a start in any non-IDLE state.
- Valid beats always present branch values; their values are don't-care when the valid is 0.
- Counters must not wrap: wr_cnt stops at K, and the read address stops at 0.

Decomposition:
- Package siso_pkg holds:
  - state typedef (IDLE/FWD/BWD/DONE encoded 00/01/10/11, shared with alpha/beta);
  - LLR_W, BM_W, MIN_K, MAX_K constants;
  - a branch-metric pair struct {branch1, branch2}.
- One sub-module: bm_frame_ram, a simple dual-port synchronous RAM.
  - Depth MAX_K, width 2·BM_W.
  - Write port and read port on clk; 1-cycle read latency; no reset.

Test Plan:
- Metric values: start K=40, sample 0 = s=10, p=4, a=2 → fwd beat branch1=8, branch2=4. Sample 1 = s=−7, p=0, a=0 → branch1=−4, branch2=−4 (floor).
- Ready pacing: K=40 with in_valid held high continuously → in_ready toggles 1,0,1,0. Exactly 40 fwd_valid beats, each isolated by a low cycle. fsm_state is 01 from the cycle after start through the cycle after the 40th accept.
- Reverse replay: K=40 with samples s=i, p=0, a=0 → bwd beats carry branch1 = i>>>1 in order i=39..0. bwd_last is asserted only on the i=0 beat. fsm_state goes 10 → 11 for one cycle → 00.
- Length limits:
  - start with K=39 → len_err pulse, fsm_state stays 00, in_ready 0.
  - K=6145 → same as K=39.
  - K=6144 → accepted, 6144 fwd and 6144 bwd beats.
- Reset mid-frame: rst asserted after the 20th accept → next cycle all outputs 0 and fsm_state 00. A new start with K=40 then runs a clean full frame.
- Start outside IDLE: start pulses during FWD and during BWD → ignored; beat counts and ordering unchanged.
